// File: rtl/mips_loader_if.sv
// +----------------------------------------------------------------------+
// | mips_loader_if : byte-stream, memory-write and status bundle          |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface mips_loader_if #(
  parameter int ADDR_W = 10
);
  logic              load_start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_start;

  // master: host/byte source and consumer of memory writes
  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_start
  );

  // slave: the loader itself
  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_start
  );
endinterface

`default_nettype wire

// File: rtl/mips_loader.sv
// +----------------------------------------------------------------------+
// | mips_loader : big-endian byte stream -> 32-bit word memory loader     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_loader #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  mips_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_FIN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0]       c_LIMIT = 32'((2 ** ADDR_W) - BASE);
  localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_core_start;
  logic [1:0]        r_bcnt;
  logic [ADDR_W:0]   r_wcnt;
  logic [15:0]       r_n;
  logic [23:0]       r_shift;

  logic              w_xfer;
  logic [15:0]       w_n;
  logic              w_last_word;

  assign w_xfer      = bus.in_valid && r_in_ready;
  // header high byte sits in the low byte of the shift register
  assign w_n         = {r_shift[7:0], bus.in_data};
  assign w_last_word = (32'(r_wcnt) + 32'd1) == 32'(r_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
      r_bcnt       <= '0;
      r_wcnt       <= '0;
      r_n          <= '0;
      r_shift      <= '0;
    end else begin
      r_mem_we     <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_state    <= S_HDR;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_bcnt     <= '0;
            r_wcnt     <= '0;
            r_n        <= '0;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            if (r_bcnt == 2'd0) begin
              r_shift[7:0] <= bus.in_data;
              r_bcnt       <= 2'd1;
            end else begin
              r_n    <= w_n;
              r_bcnt <= 2'd0;
              if (w_n == 16'd0) begin
                r_state      <= S_FIN;
                r_in_ready   <= 1'b0;
                r_core_start <= 1'b1;
              end else if ({16'd0, w_n} > c_LIMIT) begin
                r_state    <= S_ERR;
                r_in_ready <= 1'b0;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= c_BASE + r_wcnt[ADDR_W-1:0];
              r_mem_wdata <= {r_shift, bus.in_data};
              r_wcnt      <= r_wcnt + 1'b1;
              // FIN coincides with the final write strobe
              if (w_last_word) begin
                r_state      <= S_FIN;
                r_in_ready   <= 1'b0;
                r_core_start <= 1'b1;
              end
            end else begin
              r_shift <= {r_shift[15:0], bus.in_data};
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.core_start = r_core_start;

endmodule

`default_nettype wire

// File: tb/tb_mips_loader.sv
// +----------------------------------------------------------------------+
// | tb_mips_loader : directed self-checking bench for mips_loader         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mips_loader;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst;

  mips_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_loader #(.ADDR_W(ADDR_W), .BASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cs_cnt   = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  // write/core_start observer, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (bus.core_start) cs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    cs_cnt = 0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 3; k >= 0; k--) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp[$]);
    check({tag, "_nwr"}, 32'(wa.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wa.size(); i++) begin
      check({tag, "_addr"}, 32'(wa[i]), 32'(i));
      check({tag, "_data"}, wd[i], exp[i]);
    end
  endtask

  logic [31:0] fact[$];
  logic [31:0] three[$];
  logic [31:0] two[$];
  logic [31:0] one[$];
  logic [31:0] none[$];

  initial begin
    fact  = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
              32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
              32'h3460fffc, 32'h2542fffe, 32'hfc000000};
    three = '{32'h11223344, 32'haabbccdd, 32'h00000007};
    two   = '{32'h01020304, 32'h05060708};
    one   = '{32'hdeadbeef};
    none.delete();

    rst = 1'b1;
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_core_start", 32'(bus.core_start), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    idle(2);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // factorial program, back-to-back bytes
    clear_mon();
    start_load();
    check("fact_busy", 32'(bus.busy), 32'd1);
    check("fact_hdr_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h0B);
    foreach (fact[i]) send_word(fact[i], 0);
    check("fact_last_we", 32'(bus.mem_we), 32'd1);
    check("fact_cs_with_we", 32'(bus.core_start), 32'd1);
    check("fact_ready_off", 32'(bus.in_ready), 32'd0);
    idle(3);
    check_writes("fact", fact);
    check("fact_cs_cnt", 32'(cs_cnt), 32'd1);
    check("fact_done", 32'(bus.done), 32'd1);
    check("fact_busy_off", 32'(bus.busy), 32'd0);
    check("fact_err", 32'(bus.err), 32'd0);

    // zero-length session
    clear_mon();
    start_load();
    check("n0_done_cleared", 32'(bus.done), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("n0_cs_pulse", 32'(bus.core_start), 32'd1);
    idle(1);
    check("n0_cs_one_cycle", 32'(bus.core_start), 32'd0);
    check("n0_done", 32'(bus.done), 32'd1);
    idle(2);
    check_writes("n0", none);
    check("n0_cs_cnt", 32'(cs_cnt), 32'd1);

    // oversize header 0x0401
    clear_mon();
    start_load();
    send_byte(8'h04);
    send_byte(8'h01);
    check("big_no_cs", 32'(bus.core_start), 32'd0);
    idle(2);
    check("big_err", 32'(bus.err), 32'd1);
    check("big_done", 32'(bus.done), 32'd0);
    check("big_in_ready", 32'(bus.in_ready), 32'd0);
    check("big_busy", 32'(bus.busy), 32'd0);
    check_writes("big", none);
    check("big_cs_cnt", 32'(cs_cnt), 32'd0);

    // 1024 words is exactly the limit: accepted into LOAD, then aborted by reset
    clear_mon();
    start_load();
    check("lim_err_cleared", 32'(bus.err), 32'd0);
    send_byte(8'h04);
    send_byte(8'h00);
    idle(2);
    check("lim_ready", 32'(bus.in_ready), 32'd1);
    check("lim_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    #1;
    check("lim_rst_ready", 32'(bus.in_ready), 32'd0);
    check("lim_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // gapped stream, two gap patterns
    for (int p = 0; p < 2; p++) begin
      clear_mon();
      start_load();
      idle(p * 2);
      send_byte(8'h00);
      idle(p);
      send_byte(8'h03);
      foreach (three[i]) send_word(three[i], p * 3);
      idle(3);
      check_writes("gap", three);
      check("gap_done", 32'(bus.done), 32'd1);
      check("gap_cs_cnt", 32'(cs_cnt), 32'd1);
    end

    // reset after 6 bytes (header + first word) of a 2-word session
    clear_mon();
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(two[0], 0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check_writes("mid_rst", none);
    check("mid_rst_cs", 32'(cs_cnt), 32'd0);
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(one[0], 0);
    idle(3);
    check_writes("fresh", one);
    check("fresh_done", 32'(bus.done), 32'd1);
    check("fresh_cs_cnt", 32'(cs_cnt), 32'd1);

    // load_start during LOAD must be ignored
    clear_mon();
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    start_load();
    check("ls_busy", 32'(bus.busy), 32'd1);
    check("ls_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(two[1], 0);
    idle(3);
    check_writes("ls", two);
    check("ls_done", 32'(bus.done), 32'd1);
    check("ls_cs_cnt", 32'(cs_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_loader.md
MIPS_LOADER -- requirements
Module: mips_loader

Interface
- REQ-001 Parameter ADDR_W, default 10, memory word-address width (1024-word instruction/data memory).
- REQ-002 Parameter BASE, default 0, first word address written.
- REQ-003 clk  input  1  single system clock, all state updates on rising edge.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 load_start  input  1  one-cycle request to begin a load session.
- REQ-006 in_valid  input  1  byte-stream source has a byte.
- REQ-007 in_data  input  8  byte payload.
- REQ-008 in_ready  output  1  loader accepts a byte this cycle.
- REQ-009 mem_we  output  1  one-cycle memory write strobe.
- REQ-010 mem_addr  output  ADDR_W  word address of the write.
- REQ-011 mem_wdata  output  32  word written.
- REQ-012 busy  output  1  session in progress.
- REQ-013 done  output  1  last session completed successfully.
- REQ-014 err  output  1  last session rejected (word count too large).
- REQ-015 core_start  output  1  one-cycle pulse releasing the pipelined core (PC=0, HALTED=0 by the consumer).

Function
- REQ-016 States: IDLE, HDR, LOAD, FIN, ERR; one byte transfers on a cycle with in_valid && in_ready.
- REQ-017 IDLE: in_ready=0; load_start moves to HDR next cycle, clears done/err, sets busy.
- REQ-018 load_start while busy is ignored.
- REQ-019 HDR: in_ready=1; two bytes form 16-bit word count N, big-endian (first byte = N[15:8]).
- REQ-020 After the second header byte: N=0 -> FIN; N > 2^ADDR_W - BASE -> ERR; else -> LOAD.
- REQ-021 LOAD: in_ready=1; each 4 accepted bytes form one word, big-endian (first byte = bits 31:24).
- REQ-022 The cycle after the 4th byte of word i is accepted, mem_we=1, mem_addr=BASE+i, mem_wdata=word, for exactly one cycle.
- REQ-023 Back-to-back bytes at 1 byte/cycle are accepted with no stalls; a write strobe does not deassert in_ready.
- REQ-024 Gaps in in_valid are allowed anywhere; partial-word bytes are held indefinitely.
- REQ-025 After word N-1 is accepted -> FIN; in_ready=0 from the following cycle.
- REQ-026 FIN (one cycle, coincident with the final mem_we when N>0): core_start=1, busy->0, done->1, -> IDLE.
- REQ-027 ERR (one cycle): no mem_we ever issued for the session, no core_start, busy->0, err->1, -> IDLE.
- REQ-028 done/err hold until the next load_start or reset.
- REQ-029 Word index counter ADDR_W+1 bits; mem_addr never wraps within a legal session.

Reset
- REQ-030 rst asserted at any time immediately forces IDLE; in_ready, mem_we, busy, done, err, core_start = 0; mem_addr, mem_wdata, byte counter, word counter, N = 0.
- REQ-031 Reset mid-session discards partial words; no write or core_start occurs for that session; first cycle after release is IDLE.

Verification
- REQ-032 Factorial program: load_start, header 00 0B, then 44 bytes for 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000 at 1 byte/cycle -> 11 writes addr 0..10 with those values in order, one core_start pulse, done=1.
- REQ-033 Header 00 00 -> no mem_we, core_start pulse 1 cycle after 2nd header byte, done=1.
- REQ-034 Header 04 01 (1025 words, ADDR_W=10, BASE=0) -> ERR, err=1, zero writes, no core_start, in_ready=0 afterwards.
- REQ-035 Random in_valid gaps on a 3-word load (11223344, aabbccdd, 00000007) -> identical writes to addr 0..2 regardless of gap pattern.
- REQ-036 rst pulsed after 6 bytes of a 2-word load -> all outputs 0 immediately, no write; fresh load_start with 1 word deadbeef -> single write addr 0 = deadbeef, done=1.
- REQ-037 load_start asserted during LOAD -> ignored; session completes with original N.
